// File: rtl/gelu_stream_feeder.sv
// Activation stream feeder: reads int8 words from BRAM and emits NUM_LANE-wide beats.
// Optional stall-cycle counter port is enabled by defining FEEDER_STALL_CNT_EN.
module gelu_stream_feeder #(
    parameter int NUM_LANE = 4,
    parameter int ADDR_W   = 10,
    parameter int LEN_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [LEN_W-1:0]        len,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic [NUM_LANE*8-1:0]   rd_data,
    output logic [NUM_LANE*8-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic [NUM_LANE-1:0]     out_keep
`ifdef FEEDER_STALL_CNT_EN
    ,output logic [15:0]            stall_cnt
`endif
);

    localparam int DATA_W = NUM_LANE * 8;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [LEN_W-1:0]    r_len, r_reads_left;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_inflight, r_inflight_last;
    logic [DATA_W-1:0]   r_mem [2];
    logic [1:0]          r_mem_last;
    logic                r_wr_ptr, r_rd_ptr;
    logic [1:0]          r_occ;

    logic                w_start_ok, w_rd_en, w_valid, w_pop, w_pop_fifo, w_push;
    logic [1:0]          w_credit;
    logic [LEN_W-1:0]    w_beats, w_rem;
    logic [DATA_W-1:0]   w_head_data;
    logic                w_head_last;
    logic [NUM_LANE-1:0] w_keep_last, w_keep;

    assign w_start_ok = start && (r_state == S_IDLE);
    assign w_beats    = len / LEN_W'(NUM_LANE) + LEN_W'(len % LEN_W'(NUM_LANE) != '0);
    assign w_rem      = r_len % LEN_W'(NUM_LANE);
    // Credit counts buffered beats plus the read whose data arrives this cycle.
    assign w_credit   = r_occ + {1'b0, r_inflight};

    // The beat arriving from BRAM falls through to the output when the buffer is empty.
    assign w_valid     = (r_occ != 2'd0) || r_inflight;
    assign w_head_data = (r_occ != 2'd0) ? r_mem[r_rd_ptr] : rd_data;
    assign w_head_last = (r_occ != 2'd0) ? r_mem_last[r_rd_ptr] : r_inflight_last;
    assign w_pop       = w_valid && out_ready;
    assign w_pop_fifo  = w_pop && (r_occ != 2'd0);
    assign w_push      = r_inflight && !(w_pop && (r_occ == 2'd0));

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = (len != '0) ? S_RUN : S_DONE;
            S_RUN: begin
                w_rd_en = (w_credit < 2'd2);
                if (w_rd_en && (r_reads_left == LEN_W'(1))) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: if (w_pop && w_head_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_len           <= '0;
            r_reads_left    <= '0;
            r_addr          <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_inflight      <= w_rd_en;
            r_inflight_last <= w_rd_en && (r_reads_left == LEN_W'(1));
            if (w_start_ok) begin
                r_len        <= len;
                r_addr       <= base_addr;
                r_reads_left <= w_beats;
            end else if (w_rd_en) begin
                r_addr       <= r_addr + ADDR_W'(1);
                r_reads_left <= r_reads_left - LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push)     r_wr_ptr <= ~r_wr_ptr;
            if (w_pop_fifo) r_rd_ptr <= ~r_rd_ptr;
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop_fifo};
        end
    end

    // NOTE: buffer storage is not reset; its contents only reach the outputs behind r_occ.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr]      <= rd_data;
            r_mem_last[r_wr_ptr] <= r_inflight_last;
        end
    end

    // NOTE: combinational blocks assign defaults first so no path leaves a latch behind.
    always_comb begin
        w_keep_last = '0;
        for (int i = 0; i < NUM_LANE; i++)
            w_keep_last[i] = (w_rem == '0) || (LEN_W'(i) < w_rem);
    end

    assign w_keep = w_head_last ? w_keep_last : '1;

    always_comb begin
        out_data = '0;
        for (int i = 0; i < NUM_LANE; i++)
            if (w_valid && w_keep[i]) out_data[8*i +: 8] = w_head_data[8*i +: 8];
    end

    assign out_valid = w_valid;
    assign out_last  = w_valid && w_head_last;
    assign out_keep  = w_valid ? w_keep : '0;
    assign rd_en     = w_rd_en;
    assign rd_addr   = r_addr;
    assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (w_start_ok)
            r_stall_cnt <= '0;
        else if (w_valid && !out_ready && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_gelu_stream_feeder.sv
// Directed, table-driven bench for gelu_stream_feeder with a BRAM model and beat monitor.
module tb_gelu_stream_feeder;

    localparam int NL = 4;
    localparam int AW = 10;
    localparam int LW = 16;
    localparam int DW = NL * 8;

    logic          clk = 1'b0;
    logic          rst_n, start, busy, done, rd_en, out_valid, out_ready, out_last;
    logic [AW-1:0] base_addr, rd_addr;
    logic [LW-1:0] len;
    logic [DW-1:0] rd_data, out_data;
    logic [NL-1:0] out_keep;
`ifdef FEEDER_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    gelu_stream_feeder #(.NUM_LANE(NL), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_keep(out_keep)
`ifdef FEEDER_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {logic [DW-1:0] data; logic [NL-1:0] keep; logic last; int cyc;} beat_t;
    typedef struct {logic [AW-1:0] addr; int cyc;} rd_t;
    typedef struct {
        logic [AW-1:0] base;
        logic [LW-1:0] len;
        bit            toggle;
        bit            poke;
        int            exp_beats;
        logic [NL-1:0] exp_last_keep;
    } vec_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    beat_t beat_q[$];
    rd_t   rd_q[$];
    int    done_q[$];
    int    vrise_q[$];
    int    busy_cyc = 0, stall_cyc = 0, hold_viol = 0;
    logic  hold_pend = 1'b0, prev_valid = 1'b0;
    beat_t hold_b;

    function automatic logic [DW-1:0] bram_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        for (int j = 0; j < NL; j++) w[8*j +: 8] = 8'(int'(a) * 3 + j * 61 + 7);
        return w;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rd_data <= rd_en ? bram_word(rd_addr) : DW'($urandom);

    // Monitor: samples on the falling edge, records reads, handshakes, done and stalls.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend  = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (rd_en) rd_q.push_back('{rd_addr, cyc});
            if (hold_pend && !(out_valid && out_data == hold_b.data &&
                               out_keep == hold_b.keep && out_last == hold_b.last))
                hold_viol++;
            hold_pend = out_valid && !out_ready;
            hold_b    = '{out_data, out_keep, out_last, cyc};
            if (out_valid && !prev_valid) vrise_q.push_back(cyc);
            prev_valid = out_valid;
            if (out_valid && !out_ready) stall_cyc++;
            if (out_valid && out_ready) beat_q.push_back('{out_data, out_keep, out_last, cyc});
            if (done) done_q.push_back(cyc);
            if (busy) busy_cyc++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v, input string tag);
        int b0, r0, d0, v0, bz0, s_cyc, nb, nr, waited, max_ahead, acc, lhs;
        logic [DW-1:0] w, ed;
        logic [NL-1:0] ek;
`ifdef FEEDER_STALL_CNT_EN
        int st0;
        st0 = stall_cyc;
`endif
        b0 = beat_q.size(); r0 = rd_q.size(); d0 = done_q.size(); v0 = vrise_q.size();
        bz0 = busy_cyc;
        @(posedge clk); #1;
        start = 1'b1; base_addr = v.base; len = v.len; s_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0; base_addr = AW'($urandom); len = LW'($urandom);
        waited = 0;
        while (done_q.size() == d0 && waited < 400) begin
            if (v.toggle) out_ready = ~out_ready;
            start = v.poke && (waited == 4);
            @(posedge clk); #1;
            waited++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_count"}, done_q.size() - d0, 1);
        nb = beat_q.size() - b0;
        check({tag, "_beats"}, nb, v.exp_beats);
        for (int i = 0; i < nb && i < v.exp_beats; i++) begin
            w = bram_word(AW'(v.base + AW'(i)));
            ed = '0;
            ek = '0;
            for (int j = 0; j < NL; j++)
                if (i * NL + j < int'(v.len)) begin
                    ed[8*j +: 8] = w[8*j +: 8];
                    ek[j] = 1'b1;
                end
            check($sformatf("%s_data%0d", tag, i), beat_q[b0+i].data, ed);
            check($sformatf("%s_keep%0d", tag, i), beat_q[b0+i].keep, ek);
            check($sformatf("%s_last%0d", tag, i), beat_q[b0+i].last, i == v.exp_beats - 1);
        end
        if (nb > 0) check({tag, "_table_last_keep"}, beat_q[b0+nb-1].keep, v.exp_last_keep);
        nr = rd_q.size() - r0;
        check({tag, "_reads"}, nr, v.exp_beats);
        for (int i = 0; i < nr && i < v.exp_beats; i++)
            check($sformatf("%s_addr%0d", tag, i), rd_q[r0+i].addr, AW'(v.base + AW'(i)));
        check({tag, "_rd_latency"}, (nr > 0) ? rd_q[r0].cyc - s_cyc : -1, 1);
        check({tag, "_valid_latency"}, (vrise_q.size() > v0) ? vrise_q[v0] - s_cyc : -1, 2);
        lhs = (nb > 0) ? beat_q[b0+nb-1].cyc : -100;
        check({tag, "_done_after_last"}, (done_q.size() > d0) ? done_q[d0] - lhs : -1, 1);
        if (done_q.size() > d0)
            check({tag, "_busy_cycles"}, busy_cyc - bz0, done_q[d0] - s_cyc - 1);
        max_ahead = 0;
        for (int i = 0; i < nr; i++) begin
            acc = 0;
            for (int k = b0; k < beat_q.size(); k++) if (beat_q[k].cyc < rd_q[r0+i].cyc) acc++;
            if (i + 1 - acc > max_ahead) max_ahead = i + 1 - acc;
        end
        check({tag, "_reads_ahead_le2"}, max_ahead <= 2, 1);
        check({tag, "_stall_hold"}, hold_viol, 0);
        if (!v.toggle && nb > 0)
            check({tag, "_throughput"}, lhs - beat_q[b0].cyc, v.exp_beats - 1);
`ifdef FEEDER_STALL_CNT_EN
        check({tag, "_stall_cnt"}, stall_cnt, stall_cyc - st0);
`endif
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_keep"}, out_keep, 0);
    endtask

    initial begin
        vec_t vecs[8];
        vec_t clean;
        int d0, r0, v0, b0, s_cyc, waited, beats_at_rst;

        vecs[0] = '{10'h010, 16'd8,  1'b0, 1'b0, 2,  4'hF};
        vecs[1] = '{10'h020, 16'd6,  1'b0, 1'b0, 2,  4'b0011};
        vecs[2] = '{10'h100, 16'd40, 1'b1, 1'b1, 10, 4'hF};
        vecs[3] = '{10'h3FF, 16'd8,  1'b0, 1'b0, 2,  4'hF};
        vecs[4] = '{10'h050, 16'd5,  1'b0, 1'b0, 2,  4'b0001};
        vecs[5] = '{10'h060, 16'd1,  1'b1, 1'b0, 1,  4'b0001};
        vecs[6] = '{10'h070, 16'd7,  1'b1, 1'b0, 2,  4'b0111};
        vecs[7] = '{10'h2F0, 16'd13, 1'b0, 1'b0, 4,  4'b0001};
        clean   = '{10'h080, 16'd12, 1'b0, 1'b0, 3,  4'hF};

        rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_job(vecs[i], $sformatf("vec%0d", i));

        // Zero-length job: done without any read or beat.
        d0 = done_q.size(); r0 = rd_q.size(); v0 = vrise_q.size();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'h123; len = '0; s_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 6; c++) begin @(posedge clk); #1; end
        check("len0_done_count", done_q.size() - d0, 1);
        check("len0_done_within_2", (done_q.size() > d0) &&
              (done_q[d0] - s_cyc >= 1) && (done_q[d0] - s_cyc <= 2), 1);
        check("len0_reads", rd_q.size() - r0, 0);
        check("len0_valid", vrise_q.size() - v0, 0);

        // Reset in the middle of a 40-element job after three beats.
        d0 = done_q.size(); b0 = beat_q.size();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'h200; len = 16'd40;
        @(posedge clk); #1;
        start = 1'b0;
        waited = 0;
        while (beat_q.size() - b0 < 3 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        check("midrst_reached_3_beats", beat_q.size() - b0, 3);
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("midrst");
        beats_at_rst = beat_q.size();
        @(posedge clk); #1;
        rst_n = 1'b1;
        r0 = rd_q.size();
        for (int c = 0; c < 6; c++) begin @(posedge clk); #1; end
        check("midrst_no_done", done_q.size() - d0, 0);
        check("midrst_no_beats", beat_q.size() - beats_at_rst, 0);
        check("midrst_no_reads", rd_q.size() - r0, 0);
        run_job(clean, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
